// File: rtl/rom_dp_loader.sv
// rom_dp_loader: dual-port word RAM that zero-fills itself after reset and packs the byte-wide ioctl download into words (optional DP_CHECKSUM_EN adds dl_sum_o)
module rom_dp_loader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int LOAD_BASE = 0,
  parameter int IOCTL_AW  = 25
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [ADDR_W-1:0]   addr_a_i,
  input  logic [DATA_W-1:0]   data_a_i,
  input  logic                we_a_i,
  output logic [DATA_W-1:0]   q_a_o,
  input  logic                dl_busy_i,
  input  logic                dl_wr_i,
  input  logic [IOCTL_AW-1:0] dl_addr_i,
  input  logic [7:0]          dl_data_i,
  output logic                ready_o
`ifdef DP_CHECKSUM_EN
  , output logic [7:0]        dl_sum_o
`endif
);
  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LW = BYTES > 1 ? $clog2(BYTES) : 1;
  localparam logic [IOCTL_AW-1:0] BASE = IOCTL_AW'(LOAD_BASE);
  localparam logic [IOCTL_AW:0] LIM = (IOCTL_AW + 1)'(DEPTH * BYTES);
  localparam logic [LW-1:0] LAST = LW'(BYTES - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d, pword_q, pword_d, wr_addr_q, wr_addr_d, word, addr_b;
  logic [DATA_W-1:0] plane_q, plane_d, wr_data_q, wr_data_d, merged, data_b, q_a_q, q_a_d;
  logic pend_q, pend_d, wr_q, wr_d, accept, evict, flush_wr, we_b, we_a_ok;
  logic [IOCTL_AW-1:0] off;
  logic [LW-1:0] lane;
  logic [DATA_W-1:0] mem [DEPTH];
  assign off = dl_addr_i - BASE;
  assign word = ADDR_W'(off / IOCTL_AW'(BYTES));
  assign lane = LW'(off % IOCTL_AW'(BYTES));
  assign accept = dl_wr_i && dl_busy_i && (state_q == LOAD || state_q == IDLE)
                  && dl_addr_i >= BASE && {1'b0, off} < LIM;
  assign evict = accept && pend_q && word != pword_q;
  assign flush_wr = state_q == FLUSH && pend_q;
  assign ready_o = state_q == IDLE;
  assign we_a_ok = we_a_i && ready_o;
  assign we_b = state_q == CLEAR || wr_q || evict || flush_wr;
  assign addr_b = state_q == CLEAR ? clr_q : wr_q ? wr_addr_q : pword_q;
  assign data_b = state_q == CLEAR ? '0 : wr_q ? wr_data_q : plane_q;
  assign q_a_d = (we_b && addr_b == addr_a_i) ? data_b : we_a_ok ? data_a_i : mem[addr_a_i];
  assign q_a_o = q_a_q;
  // Sequencing: clear sweep, idle, download, then a single flush cycle.
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    unique case (state_q)
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = dl_busy_i ? LOAD : IDLE;
      end
      IDLE:  state_d = dl_busy_i ? LOAD : IDLE;
      LOAD:  state_d = dl_busy_i ? LOAD : FLUSH;
      FLUSH: state_d = IDLE;
    endcase
  end
  // Drop the incoming byte into its lane; an evicted word restarts from zero lanes.
  always_comb begin
    merged = evict ? '0 : plane_q;
    for (int i = 0; i < BYTES; i++)
      if (lane == LW'(i)) merged[8*i +: 8] = dl_data_i;
  end
  // Byte packer: a word completes on its top lane and is written one cycle later.
  always_comb begin
    pend_d = pend_q;
    pword_d = pword_q;
    plane_d = plane_q;
    wr_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept && lane == LAST) begin
      wr_d = 1'b1;
      wr_addr_d = word;
      wr_data_d = merged;
      pend_d = 1'b0;
      plane_d = '0;
    end else if (accept) begin
      pend_d = 1'b1;
      pword_d = word;
      plane_d = merged;
    end else if (state_q == FLUSH) begin
      pend_d = 1'b0;
      plane_d = '0;
    end
  end
  // Control and packer state; reset abandons any partial word and restarts the sweep.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= CLEAR;
      clr_q <= '0;
      pend_q <= 1'b0;
      pword_q <= '0;
      plane_q <= '0;
      wr_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      q_a_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      pend_q <= pend_d;
      pword_q <= pword_d;
      plane_q <= plane_d;
      wr_q <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      q_a_q <= q_a_d;
    end
  end
  // Storage array; the loader write is applied last so it wins a same-word collision.
  always_ff @(posedge clk_i) begin
    if (we_a_ok) mem[addr_a_i] <= data_a_i;
    if (we_b) mem[addr_b] <= data_b;
  end
`ifdef DP_CHECKSUM_EN
  logic busy_q;
  logic [7:0] sum_q, sum_d;
  assign sum_d = ((dl_busy_i && !busy_q) ? 8'h00 : sum_q) + (accept ? dl_data_i : 8'h00);
  assign dl_sum_o = sum_q;
  // Running byte sum, restarted at the start of every download.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      sum_q <= 8'h00;
    end else begin
      busy_q <= dl_busy_i;
      sum_q <= sum_d;
    end
  end
`endif
endmodule

// File: tb/tb_rom_dp_loader.sv
// tb_rom_dp_loader: vector table, directed corner cases and random downloads against a byte-run model
module tb_rom_dp_loader;
  logic clk = 1'b0, reset = 1'b1, we_a = 1'b0, dl_busy = 1'b0, dl_wr = 1'b0, ready;
  logic [3:0] addr_a = '0;
  logic [15:0] data_a = '0, q_a;
  logic [24:0] dl_addr = '0;
  logic [7:0] dl_data = '0;
`ifdef DP_CHECKSUM_EN
  logic [7:0] dl_sum;
`endif
  int checks = 0, errors = 0;
  logic [15:0] mdl [16];
  bit cur_p;
  int cur_w;
  logic [15:0] cur_v;

  rom_dp_loader #(.DATA_W(16), .ADDR_W(4), .LOAD_BASE('h100), .IOCTL_AW(25)) dut (
    .clk_i(clk), .reset_i(reset), .addr_a_i(addr_a), .data_a_i(data_a), .we_a_i(we_a),
    .q_a_o(q_a), .dl_busy_i(dl_busy), .dl_wr_i(dl_wr), .dl_addr_i(dl_addr),
    .dl_data_i(dl_data), .ready_o(ready)
`ifdef DP_CHECKSUM_EN
    , .dl_sum_o(dl_sum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
    cur_p = 0;
    cur_v = 16'h0;
  endtask

  task automatic commit();
    mdl[cur_w] = cur_v;
    cur_p = 0;
    cur_v = 16'h0;
  endtask

  task automatic wait_ready(input string name, output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) chk({name, "_ready_timeout"}, {31'h0, ready}, 32'h1);
  endtask

  task automatic byte_wr(input logic [24:0] a, input logic [7:0] d);
    int off, w, l;
    dl_wr = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr = 1'b0;
    if (a >= 25'h100 && a - 25'h100 < 32) begin
      off = int'(a) - 'h100;
      w = off / 2;
      l = off % 2;
      if (cur_p && cur_w != w) commit();
      cur_p = 1;
      cur_w = w;
      cur_v[8*l +: 8] = d;
      if (l == 1) commit();
    end
  endtask

  task automatic dl_start(input string name);
    int n;
    chk({name, "_ready_before"}, {31'h0, ready}, 32'h1);
    dl_busy = 1'b1;
    tick();
    chk({name, "_ready_drop"}, {31'h0, ready}, 32'h0);
    cur_p = 0;
    cur_v = 16'h0;
  endtask

  task automatic dl_end(input string name);
    int n;
    dl_busy = 1'b0;
    if (cur_p) commit();
    wait_ready(name, n);
  endtask

  task automatic rd_all(input string name);
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      tick();
      chk($sformatf("%s_w%0d", name, i), {16'h0, q_a}, {16'h0, mdl[i]});
    end
  endtask

  typedef struct {bit we; logic [3:0] a; logic [15:0] d; logic [15:0] exp;} vec_t;
  vec_t tbl [6];

  initial begin
    int n;
    logic [24:0] a;
    logic [15:0] d;
    tbl[0] = '{1'b1, 4'd3, 16'h005A, 16'h005A};
    tbl[1] = '{1'b0, 4'd3, 16'h0000, 16'h005A};
    tbl[2] = '{1'b0, 4'd2, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 4'd15, 16'hBEEF, 16'hBEEF};
    tbl[4] = '{1'b0, 4'd15, 16'h0000, 16'hBEEF};
    tbl[5] = '{1'b1, 4'd2, 16'hFFFF, 16'hFFFF};
    model_clear();
    tick();
    tick();
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_q_a", {16'h0, q_a}, 32'h0);
    reset = 1'b0;
    wait_ready("clear", n);
    chk("clear_cycles", n, 16);
    rd_all("cleared");
    for (int i = 0; i < 6; i++) begin
      addr_a = tbl[i].a;
      data_a = tbl[i].d;
      we_a = tbl[i].we;
      tick();
      we_a = 1'b0;
      if (tbl[i].we) mdl[tbl[i].a] = tbl[i].d;
      chk($sformatf("vec%0d", i), {16'h0, q_a}, {16'h0, tbl[i].exp});
    end
    dl_start("t2");
    addr_a = 4'd9;
    data_a = 16'h1234;
    we_a = 1'b1;
    tick();
    we_a = 1'b0;
    byte_wr(25'h0FF, 8'hAA);
    byte_wr(25'h100, 8'h11);
    byte_wr(25'h101, 8'h22);
    tick();
    byte_wr(25'h102, 8'h33);
    byte_wr(25'h103, 8'h44);
    dl_end("t2");
    addr_a = 4'd0;
    tick();
    chk("t2_word0", {16'h0, q_a}, 32'h2211);
    addr_a = 4'd1;
    tick();
    chk("t2_word1", {16'h0, q_a}, 32'h4433);
    rd_all("t2");
    dl_start("t3");
    byte_wr(25'h104, 8'h55);
    dl_end("t3");
    addr_a = 4'd2;
    tick();
    chk("t3_flush_word2", {16'h0, q_a}, 32'h0055);
    dl_start("coll");
    addr_a = 4'd0;
    byte_wr(25'h100, 8'h77);
    byte_wr(25'h101, 8'h88);
    tick();
    chk("collision_q_a", {16'h0, q_a}, 32'h8877);
    dl_end("coll");
    rd_all("coll");
`ifdef DP_CHECKSUM_EN
    dl_start("t6");
    byte_wr(25'h108, 8'h01);
    byte_wr(25'h109, 8'h02);
    byte_wr(25'h10A, 8'hFF);
    byte_wr(25'h0FE, 8'h40);
    dl_end("t6");
    chk("t6_sum", {24'h0, dl_sum}, 32'h02);
    dl_start("t6b");
    chk("t6_sum_restart", {24'h0, dl_sum}, 32'h00);
    dl_end("t6b");
`endif
    for (int it = 0; it < 5; it++) begin
      dl_start($sformatf("rnd%0d", it));
      a = 25'h0F8 + 25'($urandom_range(0, 8));
      n = $urandom_range(6, 24);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) a = 25'h0F0 + 25'($urandom_range(0, 'h40));
        else a = a + 25'd1;
        byte_wr(a, 8'($urandom));
        if ($urandom_range(0, 2) == 0) tick();
      end
      dl_end($sformatf("rnd%0d", it));
      for (int k = 0; k < 2; k++) begin
        addr_a = 4'($urandom);
        d = 16'($urandom);
        data_a = d;
        we_a = 1'b1;
        tick();
        we_a = 1'b0;
        mdl[addr_a] = d;
        chk($sformatf("rnd%0d_wt%0d", it, k), {16'h0, q_a}, {16'h0, d});
      end
      rd_all($sformatf("rnd%0d", it));
    end
    dl_start("t5");
    for (int k = 0; k < 10; k++) byte_wr(25'h100 + 25'(k), 8'(k + 'h31));
    reset = 1'b1;
    dl_busy = 1'b0;
    #1;
    chk("t5_reset_ready", {31'h0, ready}, 32'h0);
    chk("t5_reset_q_a", {16'h0, q_a}, 32'h0);
    tick();
    reset = 1'b0;
    model_clear();
    wait_ready("t5", n);
    chk("t5_clear_cycles", n, 16);
    rd_all("t5");
    reset = 1'b1;
    dl_busy = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("holdoff_ready", {31'h0, ready}, 32'h0);
    model_clear();
    byte_wr(25'h106, 8'h99);
    byte_wr(25'h107, 8'hAB);
    dl_end("holdoff");
    addr_a = 4'd3;
    tick();
    chk("holdoff_word3", {16'h0, q_a}, 32'hAB99);
    rd_all("holdoff");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
